serial_subtractor_16b: RTL and testbench

//  Multi-cycle digit-serial two's-complement subtractor; the inverse operation to full_adder_16b.

---
 rtl/arith_pkg.sv | 15 +
 rtl/digit_adder.sv | 28 ++
 rtl/serial_subtractor_16b.sv | 107 ++++++++++
 tb/tb_serial_subtractor_16b.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath package.
// Holds the multi-cycle FSM state type and the default operand geometry
// used by serial_subtractor_16b and the full_adder_16b benches.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned ARITH_WIDTH = 16;
  localparam int unsigned ARITH_DIGIT = 4;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from 1-bit full-adder cells.
// Ports:
//   a, b  [DIGIT-1:0]  addends
//   cin                carry in
//   sum   [DIGIT-1:0]  a + b + cin (low DIGIT bits)
//   cout               carry out of the top cell
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_subtractor_16b.sv
// Digit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH),
// borrow = (a < b) unsigned. Processes DIGIT bits per cycle as a + ~b + 1.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  operand handshake (a minuend, b subtrahend)
//   out_valid / out_ready result handshake (diff, borrow)
module serial_subtractor_16b
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH,
  parameter int unsigned DIGIT = ARITH_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor_16b: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] nb_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcout;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a    (a_sh[DIGIT-1:0]),
    .b    (nb_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout)
  );

  // RUN spends N cycles on digits and one more (cnt == N) committing the
  // result, so out_valid rises N+1 edges after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      a_sh      <= '0;
      nb_sh     <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            nb_sh    <= ~b;
            carry    <= 1'b1;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            diff      <= res;
            borrow    <= ~carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a_sh  <= a_sh >> DIGIT;
            nb_sh <= nb_sh >> DIGIT;
            res   <= {dsum, res[WIDTH-1:DIGIT]};
            carry <= dcout;
            cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_16b.sv
module tb_serial_subtractor_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] last_diff;

  serial_subtractor_16b #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge (accepted there), then wait for out_valid.
  task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tbv,
                                input bit detail, output int cyc);
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
      if (detail && cyc == 2) chk("hold_in_run", {16'h0, diff}, {16'h0, last_diff});
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                    input logic [15:0] ed, input logic eb);
    int cyc;
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    start_and_wait(ta, tbv, 1'b1, cyc);
    chk({tag, "_latency"}, cyc, 32'd5);
    chk({tag, "_result"}, {15'h0, out_valid, borrow, diff}, {15'h0, 1'b1, eb, ed});
    drain();
    chk({tag, "_release"}, {30'h0, out_valid, in_ready}, {30'h0, 1'b0, 1'b1});
    last_diff = ed;
  endtask

  initial begin
    int          cyc;
    logic [15:0] ra;
    logic [15:0] rb;
    int unsigned err0;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_state", {16'h0, in_ready, out_valid, borrow, 13'h0},
        {16'h0, 1'b1, 1'b0, 1'b0, 13'h0});
    chk("reset_diff", {16'h0, diff}, 32'h0);
    last_diff = 16'h0;

    op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0);
    op("wrap", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    op("equal_max", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    op("zero_minus_max", 16'h0000, 16'hFFFF, 16'h0001, 1'b1);

    // Backpressure: hold out_ready low for 10 cycles in DONE.
    start_and_wait(16'h1234, 16'h0234, 1'b0, cyc);
    chk("bp_reach_done", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 16'hAAAA;
      b = 16'h5555;
      step();
      chk("bp_stall", {14'h0, out_valid, in_ready, borrow, diff},
          {14'h0, 1'b1, 1'b0, 1'b0, 16'h1000});
    end
    in_valid = 1'b0;
    drain();
    chk("bp_release", {30'h0, out_valid, in_ready}, {30'h0, 1'b0, 1'b1});

    // Second in_valid during RUN must not be latched.
    a = 16'h0005;
    b = 16'h0003;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    a = 16'hFFFF;
    b = 16'h0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'h0005;
    b = 16'h0003;
    cyc = 2;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("run_ignore_latency", cyc, 32'd5);
    chk("run_ignore_result", {15'h0, out_valid, borrow, diff}, {15'h0, 1'b1, 1'b0, 16'h0002});
    drain();

    // Reset two cycles into RUN.
    a = 16'h8000;
    b = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_state", {16'h0, in_ready, out_valid, 14'h0}, {16'h0, 1'b1, 1'b0, 14'h0});
    chk("midrst_diff", {15'h0, borrow, diff}, 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("midrst_no_valid", {31'h0, out_valid}, 32'h0);
    last_diff = 16'h0;
    op("after_rst", 16'h0005, 16'h0003, 16'h0002, 1'b0);

    // Random pairs, final pair a=b=FFFF.
    for (int i = 0; i < 1000; i++) begin
      if (i == 999) begin
        ra = 16'hFFFF;
        rb = 16'hFFFF;
      end else begin
        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
      end
      err0 = errors;
      start_and_wait(ra, rb, 1'b0, cyc);
      chk("random", {14'h0, out_valid, borrow, diff}, {14'h0, 1'b1, (ra < rb), 16'(ra - rb)});
      if (errors != err0) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
